// File: rtl/monolith_rr_scheduler.sv
// Round-robin front end that shares one Monolith hash/compress engine among
// NUM_REQ requesters, one job at a time, with a watchdog that aborts hung jobs.
module monolith_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*31-1:0] req_in1,
    input  logic [NUM_REQ*31-1:0] req_in2,
    input  logic [NUM_REQ-1:0]    req_mode,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [30:0]           resp_data,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_timeout,
    output logic [30:0]           eng_in1,
    output logic [30:0]           eng_in2,
    output logic                  eng_mode,
    output logic                  eng_go,
    input  logic [30:0]           eng_out,
    input  logic                  eng_valid,
    output logic                  busy
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] job_id_q, job_id_d;
    logic [15:0]    watchdog_q, watchdog_d;
    logic [30:0]    eng_in1_q, eng_in1_d;
    logic [30:0]    eng_in2_q, eng_in2_d;
    logic           eng_mode_q, eng_mode_d;
    logic           eng_go_q, eng_go_d;
    logic           resp_valid_q, resp_valid_d;
    logic [30:0]    resp_data_q, resp_data_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic           resp_timeout_q, resp_timeout_d;

    logic [IDW-1:0] winner;
    logic           any_req;
    logic [30:0]    in1_arr [NUM_REQ];
    logic [30:0]    in2_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign in1_arr[g] = req_in1[31*g +: 31];
        assign in2_arr[g] = req_in2[31*g +: 31];
    end

    assign any_req = |req_valid;

    // Search starts just after the last winner, so the most recently served requester has lowest priority.
    always_comb begin
        int   idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE && any_req) ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        job_id_d       = job_id_q;
        watchdog_d     = watchdog_q;
        eng_in1_d      = eng_in1_q;
        eng_in2_d      = eng_in2_q;
        eng_mode_d     = eng_mode_q;
        eng_go_d       = eng_go_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_id_d      = resp_id_q;
        resp_timeout_d = resp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    eng_in1_d  = in1_arr[winner];
                    eng_in2_d  = req_mode[winner] ? in2_arr[winner] : 31'd0;
                    eng_mode_d = req_mode[winner];
                    job_id_d   = winner;
                    rr_ptr_d   = winner;
                    watchdog_d = '0;
                    eng_go_d   = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                watchdog_d = watchdog_q + 16'd1;
                if (eng_valid) begin
                    resp_data_d    = eng_out;
                    resp_id_d      = job_id_q;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = 1'b1;
                    eng_go_d       = 1'b0;
                    state_d        = S_RESP;
                end else if (watchdog_q == WD_LIMIT) begin
                    resp_data_d    = '0;
                    resp_id_d      = job_id_q;
                    resp_timeout_d = 1'b1;
                    resp_valid_d   = 1'b1;
                    eng_go_d       = 1'b0;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= IDW'(NUM_REQ - 1);
            job_id_q       <= '0;
            watchdog_q     <= '0;
            eng_in1_q      <= '0;
            eng_in2_q      <= '0;
            eng_mode_q     <= 1'b0;
            eng_go_q       <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_id_q      <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            job_id_q       <= job_id_d;
            watchdog_q     <= watchdog_d;
            eng_in1_q      <= eng_in1_d;
            eng_in2_q      <= eng_in2_d;
            eng_mode_q     <= eng_mode_d;
            eng_go_q       <= eng_go_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_id_q      <= resp_id_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign eng_in1      = eng_in1_q;
    assign eng_in2      = eng_in2_q;
    assign eng_mode     = eng_mode_q;
    assign eng_go       = eng_go_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_id      = resp_id_q;
    assign resp_timeout = resp_timeout_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_monolith_rr_scheduler.sv
// Bench for monolith_rr_scheduler: dut_a (long watchdog) for the main features,
// dut_b (8-cycle watchdog) for timeout; each drives a simple latency-based engine model.
module tb_monolith_rr_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    req_valid_a, req_ready_a, req_mode_a;
    logic [N*31-1:0] req_in1_a, req_in2_a;
    logic            resp_valid_a, resp_ready_a, resp_timeout_a;
    logic [30:0]     resp_data_a, eng_in1_a, eng_in2_a, eng_out_a;
    logic [1:0]      resp_id_a;
    logic            eng_mode_a, eng_go_a, eng_valid_a, busy_a;

    logic [N-1:0]    req_valid_b, req_ready_b, req_mode_b;
    logic [N*31-1:0] req_in1_b, req_in2_b;
    logic            resp_valid_b, resp_ready_b, resp_timeout_b;
    logic [30:0]     resp_data_b, eng_in1_b, eng_in2_b, eng_out_b;
    logic [1:0]      resp_id_b;
    logic            eng_mode_b, eng_go_b, eng_valid_b, busy_b;

    int   eng_lat_a = 20;
    int   eng_cnt_a = 0;
    int   eng_cnt_b = 0;
    logic eng_hang_b = 1'b0;
    int   rr_last = N - 1;
    int   rr_last_b = N - 1;

    logic [30:0] op1 [N];
    logic [30:0] op2 [N];
    logic        opm [N];

    monolith_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(1023)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_in1(req_in1_a), .req_in2(req_in2_a), .req_mode(req_mode_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_data(resp_data_a), .resp_id(resp_id_a), .resp_timeout(resp_timeout_a),
        .eng_in1(eng_in1_a), .eng_in2(eng_in2_a), .eng_mode(eng_mode_a), .eng_go(eng_go_a),
        .eng_out(eng_out_a), .eng_valid(eng_valid_a), .busy(busy_a)
    );

    monolith_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_in1(req_in1_b), .req_in2(req_in2_b), .req_mode(req_mode_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_data(resp_data_b), .resp_id(resp_id_b), .resp_timeout(resp_timeout_b),
        .eng_in1(eng_in1_b), .eng_in2(eng_in2_b), .eng_mode(eng_mode_b), .eng_go(eng_go_b),
        .eng_out(eng_out_b), .eng_valid(eng_valid_b), .busy(busy_b)
    );

    // Engine models: result = in1 ^ in2, valid once go has been high for the chosen latency.
    always @(posedge clk) begin
        eng_cnt_a <= (reset || !eng_go_a) ? 0 : eng_cnt_a + 1;
        eng_cnt_b <= (reset || !eng_go_b) ? 0 : eng_cnt_b + 1;
    end
    assign eng_valid_a = eng_go_a && (eng_cnt_a >= eng_lat_a);
    assign eng_out_a   = eng_in1_a ^ eng_in2_a;
    assign eng_valid_b = eng_go_b && !eng_hang_b && (eng_cnt_b >= 3);
    assign eng_out_b   = eng_in1_b ^ eng_in2_b;

    function automatic int rr_pick(int last, logic [N-1:0] v);
        int pick = -1;
        for (int k = 1; k <= N; k++) begin
            if (pick < 0 && v[(last + k) % N]) pick = (last + k) % N;
        end
        return pick;
    endfunction

    function automatic logic [30:0] model_result(logic [30:0] a, logic [30:0] b, logic m);
        return m ? (a ^ b) : a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops_a();
        for (int i = 0; i < N; i++) begin
            req_in1_a[31*i +: 31] = op1[i];
            req_in2_a[31*i +: 31] = op2[i];
            req_mode_a[i]         = opm[i];
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            op1[i] = 31'($urandom);
            op2[i] = 31'($urandom);
            opm[i] = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid_a = '0;
        req_valid_b = '0;
        tick();
        tick();
        reset = 1'b0;
        rr_last = N - 1;
        rr_last_b = N - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_a = '0; req_in1_a = '0; req_in2_a = '0; req_mode_a = '0; resp_ready_a = 1'b0;
        req_valid_b = '0; req_in1_b = '0; req_in2_b = '0; req_mode_b = '0; resp_ready_b = 1'b0;
        tick();
        tick();
        checks++;
        if ({resp_valid_a, resp_data_a, resp_id_a, resp_timeout_a} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_resp: got v=%0b d=%h id=%0d to=%0b, want all 0",
                     resp_valid_a, resp_data_a, resp_id_a, resp_timeout_a);
        end
        checks++;
        if ({eng_go_a, eng_in1_a, eng_in2_a, eng_mode_a} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_eng: got go=%0b in1=%h in2=%h mode=%0b, want all 0",
                     eng_go_a, eng_in1_a, eng_in2_a, eng_mode_a);
        end
        checks++;
        if ({req_ready_a, busy_a, eng_go_b, resp_valid_b, busy_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got rdy=%b busy=%0b b_go=%0b b_rv=%0b b_busy=%0b, want 0",
                     req_ready_a, busy_a, eng_go_b, resp_valid_b, busy_b);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_req: busy got %0b want 0", busy_a);
        end
    endtask

    task automatic test_single_hash();
        int got = 0;
        op1[2] = 31'h12345678; op2[2] = 31'h7FFFFFFF; opm[2] = 1'b0;
        drive_ops_a();
        eng_lat_a = 20;
        resp_ready_a = 1'b1;
        req_valid_a = 4'b0100;
        #1;
        checks++;
        if (req_ready_a !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL hash_grant: req_ready got %b want 0100", req_ready_a);
        end
        tick();
        req_valid_a = '0;
        rr_last = 2;
        checks++;
        if ({req_ready_a, eng_go_a, busy_a, eng_in1_a, eng_in2_a, eng_mode_a} !==
            {4'b0000, 1'b1, 1'b1, 31'h12345678, 31'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hash_run: got rdy=%b go=%0b busy=%0b in1=%h in2=%h mode=%0b, want 0000 1 1 12345678 0 0",
                     req_ready_a, eng_go_a, busy_a, eng_in1_a, eng_in2_a, eng_mode_a);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (resp_valid_a === 1'b1) begin got = k; break; end
        end
        checks++;
        if (got != 21) begin
            errors++;
            $display("[TB] FAIL hash_latency: resp_valid after %0d cycles want 21", got);
        end
        checks++;
        if ({resp_data_a, resp_id_a, resp_timeout_a, eng_go_a} !== {31'h12345678, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hash_resp: got d=%h id=%0d to=%0b go=%0b want 12345678 2 0 0",
                     resp_data_a, resp_id_a, resp_timeout_a, eng_go_a);
        end
        tick();
        checks++;
        if ({resp_valid_a, busy_a} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL hash_done: got rv=%0b busy=%0b want 0 0", resp_valid_a, busy_a);
        end
    endtask

    task automatic test_compress();
        int got = 0;
        op1[1] = 31'h0000000F; op2[1] = 31'h000000F0; opm[1] = 1'b1;
        drive_ops_a();
        req_valid_a = 4'b0010;
        #1;
        checks++;
        if (req_ready_a !== (4'(1) << rr_pick(rr_last, 4'b0010))) begin
            errors++;
            $display("[TB] FAIL comp_grant: req_ready got %b want 0010", req_ready_a);
        end
        tick();
        req_valid_a = '0;
        rr_last = 1;
        checks++;
        if ({eng_mode_a, eng_in2_a} !== {1'b1, 31'h000000F0}) begin
            errors++;
            $display("[TB] FAIL comp_eng: got mode=%0b in2=%h want 1 000000f0", eng_mode_a, eng_in2_a);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (resp_valid_a === 1'b1) begin got = k; break; end
        end
        checks++;
        if (got != 21 || {resp_data_a, resp_id_a, resp_timeout_a} !== {31'h000000FF, 2'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL comp_resp: got lat=%0d d=%h id=%0d to=%0b want 21 000000ff 1 0",
                     got, resp_data_a, resp_id_a, resp_timeout_a);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int got;
        int prev_grant = 0;
        int w;
        logic [30:0] exp;
        do_reset();
        eng_lat_a = 2;
        resp_ready_a = 1'b1;
        randomize_ops();
        drive_ops_a();
        req_valid_a = 4'hF;
        #1;
        for (int j = 0; j < 6; j++) begin
            w = j % N;
            for (int k = 0; k < 20; k++) begin
                if (req_ready_a !== '0) break;
                tick();
            end
            checks++;
            if (req_ready_a !== (4'(1) << w) || eng_go_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got rdy=%b go=%0b want %b 0", j, req_ready_a, eng_go_a, 4'(1) << w);
            end
            if (j > 0) begin
                checks++;
                if (cyc - prev_grant != eng_lat_a + 3) begin
                    errors++;
                    $display("[TB] FAIL rr_spacing%0d: got %0d cycles want %0d", j, cyc - prev_grant, eng_lat_a + 3);
                end
            end
            prev_grant = cyc;
            exp = model_result(op1[w], op2[w], opm[w]);
            tick();
            if (j == 5) req_valid_a = '0;
            got = 0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (resp_valid_a === 1'b1) begin got = k; break; end
            end
            checks++;
            if (got != eng_lat_a + 1 || resp_data_a !== exp || resp_id_a !== 2'(w)) begin
                errors++;
                $display("[TB] FAIL rr_resp%0d: got lat=%0d d=%h id=%0d want %0d %h %0d",
                         j, got, resp_data_a, resp_id_a, eng_lat_a + 1, exp, w);
            end
        end
        rr_last = 1;
        tick();
    endtask

    task automatic test_backpressure();
        int got = 0;
        logic [30:0] exp;
        resp_ready_a = 1'b0;
        eng_lat_a = 4;
        op1[3] = 31'($urandom); op2[3] = 31'($urandom); opm[3] = 1'b1;
        drive_ops_a();
        exp = model_result(op1[3], op2[3], opm[3]);
        req_valid_a = 4'b1000;
        #1;
        checks++;
        if (req_ready_a !== (4'(1) << rr_pick(rr_last, 4'b1000))) begin
            errors++;
            $display("[TB] FAIL bp_grant: req_ready got %b want 1000", req_ready_a);
        end
        tick();
        rr_last = 3;
        req_valid_a = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (resp_valid_a === 1'b1) begin got = k; break; end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("[TB] FAIL bp_latency: resp_valid after %0d cycles want 5", got);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({resp_valid_a, resp_data_a, resp_id_a, eng_go_a, req_ready_a, busy_a} !==
                {1'b1, exp, 2'd3, 1'b0, 4'b0000, 1'b1}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got rv=%0b d=%h id=%0d go=%0b rdy=%b busy=%0b want 1 %h 3 0 0000 1",
                         i, resp_valid_a, resp_data_a, resp_id_a, eng_go_a, req_ready_a, busy_a, exp);
            end
            tick();
        end
        resp_ready_a = 1'b1;
        tick();
        checks++;
        if ({resp_valid_a, busy_a, req_ready_a} !== {1'b0, 1'b0, 4'b0001}) begin
            errors++;
            $display("[TB] FAIL bp_release: got rv=%0b busy=%0b rdy=%b want 0 0 0001",
                     resp_valid_a, busy_a, req_ready_a);
        end
        req_valid_a = '0;
        tick();
    endtask

    task automatic test_timeout();
        int got = 0;
        logic [30:0] a;
        logic [30:0] b;
        do_reset();
        eng_hang_b = 1'b1;
        resp_ready_b = 1'b1;
        req_in1_b[30:0] = 31'($urandom);
        req_in2_b[30:0] = 31'($urandom);
        req_mode_b[0] = 1'b1;
        req_valid_b = 4'b0001;
        #1;
        checks++;
        if (req_ready_b !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL to_grant: req_ready got %b want 0001", req_ready_b);
        end
        tick();
        req_valid_b = '0;
        rr_last_b = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (resp_valid_b === 1'b1) begin got = k; break; end
        end
        checks++;
        if (got != 8 || {resp_timeout_b, resp_data_b, resp_id_b} !== {1'b1, 31'd0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL to_abort: got lat=%0d to=%0b d=%h id=%0d want 8 1 0 0",
                     got, resp_timeout_b, resp_data_b, resp_id_b);
        end
        tick();
        eng_hang_b = 1'b0;
        a = 31'($urandom);
        b = 31'($urandom);
        req_in1_b[62 +: 31] = a;
        req_in2_b[62 +: 31] = b;
        req_mode_b[2] = 1'b0;
        req_valid_b = 4'b0100;
        #1;
        checks++;
        if (req_ready_b !== (4'(1) << rr_pick(rr_last_b, 4'b0100))) begin
            errors++;
            $display("[TB] FAIL to_next_grant: req_ready got %b want 0100", req_ready_b);
        end
        tick();
        req_valid_b = '0;
        got = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (resp_valid_b === 1'b1) begin got = k; break; end
        end
        checks++;
        if (got != 4 || {resp_timeout_b, resp_data_b, resp_id_b} !== {1'b0, model_result(a, b, 1'b0), 2'd2}) begin
            errors++;
            $display("[TB] FAIL to_next_resp: got lat=%0d to=%0b d=%h id=%0d want 4 0 %h 2",
                     got, resp_timeout_b, resp_data_b, resp_id_b, a);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic seen = 1'b0;
        do_reset();
        eng_lat_a = 20;
        resp_ready_a = 1'b1;
        randomize_ops();
        drive_ops_a();
        req_valid_a = 4'b0100;
        tick();
        req_valid_a = '0;
        checks++;
        if (eng_go_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_go_high: eng_go got %0b want 1", eng_go_a);
        end
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({eng_go_a, resp_valid_a, busy_a} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_reset: got go=%0b rv=%0b busy=%0b want 0 0 0", eng_go_a, resp_valid_a, busy_a);
        end
        req_valid_a = 4'hF;
        #1;
        checks++;
        if (req_ready_a !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_first_winner: req_ready got %b want 0001", req_ready_a);
        end
        req_valid_a = '0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (resp_valid_a !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_no_resp: stray response got %0b want 0", seen);
        end
        rr_last = N - 1;
    endtask

    task automatic test_random();
        int got;
        int w;
        int lat;
        logic r;
        logic [30:0] exp;
        do_reset();
        for (int j = 0; j < 30; j++) begin
            lat = $urandom_range(1, 6);
            eng_lat_a = lat;
            randomize_ops();
            drive_ops_a();
            req_valid_a = 4'($urandom_range(1, 15));
            resp_ready_a = 1'($urandom);
            w = rr_pick(rr_last, req_valid_a);
            exp = model_result(op1[w], op2[w], opm[w]);
            #1;
            checks++;
            if (req_ready_a !== (4'(1) << w)) begin
                errors++;
                $display("[TB] FAIL rnd_grant%0d: req_ready got %b want %b (valid %b)",
                         j, req_ready_a, 4'(1) << w, req_valid_a);
            end
            tick();
            rr_last = w;
            req_valid_a = '0;
            got = 0;
            for (int k = 1; k <= 20; k++) begin
                resp_ready_a = 1'($urandom);
                tick();
                if (resp_valid_a === 1'b1) begin got = k; break; end
            end
            checks++;
            if (got != lat + 1 || {resp_data_a, resp_id_a, resp_timeout_a} !== {exp, 2'(w), 1'b0}) begin
                errors++;
                $display("[TB] FAIL rnd_resp%0d: got lat=%0d d=%h id=%0d to=%0b want %0d %h %0d 0",
                         j, got, resp_data_a, resp_id_a, resp_timeout_a, lat + 1, exp, w);
            end
            for (int k = 0; k < 50; k++) begin
                r = 1'($urandom);
                resp_ready_a = r;
                tick();
                if (r) break;
                checks++;
                if ({resp_valid_a, resp_data_a, resp_id_a} !== {1'b1, exp, 2'(w)}) begin
                    errors++;
                    $display("[TB] FAIL rnd_hold%0d: got rv=%0b d=%h id=%0d want 1 %h %0d",
                             j, resp_valid_a, resp_data_a, resp_id_a, exp, w);
                end
            end
            checks++;
            if ({resp_valid_a, busy_a} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL rnd_idle%0d: got rv=%0b busy=%0b want 0 0", j, resp_valid_a, busy_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hash();
        test_compress();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] bench did not terminate");
    end

endmodule

// File: doc/monolith_rr_scheduler.md
Name: monolith_rr_scheduler

Overview:
- Shares one Monolith hash/compress engine among NUM_REQ independent requesters.
- Accepts one job at a time from the requesters, using round-robin arbitration.
- Drives the engine's operand, mode and go inputs, and waits for the engine's valid.
- Returns the 31-bit result with the requester id over a valid/ready response channel. A watchdog aborts jobs that hang.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..16. Derived localparam IDW = $clog2(NUM_REQ).
- TIMEOUT_CYCLES, 1023: maximum number of RUN cycles without eng_valid before the job is aborted. Range 1..65535.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- req_in1  in  NUM_REQ*31  first operands; requester i uses bits [31*i +: 31].
- req_in2  in  NUM_REQ*31  second operands; ignored in hash mode.
- req_mode  in  NUM_REQ  0 = hash, 1 = compress.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  31  engine result, or 0 on timeout.
- resp_id  out  IDW  index of the requester that owns resp_data.
- resp_timeout  out  1  result aborted by the watchdog.
- eng_in1  out  31  engine first operand.
- eng_in2  out  31  engine second operand.
- eng_mode  out  1  engine hash_or_compress input.
- eng_go  out  1  engine go. Held high for the whole computation; low hard-resets the engine.
- eng_out  in  31  engine result.
- eng_valid  in  1  engine result valid; stays high while go stays high.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state = IDLE, req_ready = 0, resp_valid = 0, resp_data = 0, resp_id = 0, resp_timeout = 0.
- Also at reset: eng_go = 0, eng_in1/eng_in2/eng_mode = 0, rr_ptr = NUM_REQ-1 (so requester 0 wins first), watchdog = 0.
- Reset mid-job: the job is dropped with no response, and eng_go goes low on the next edge.
- FSM states are IDLE, RUN and RESP.
- IDLE:
  - The winner is the first i with req_valid[i] set, searching from rr_ptr+1 and wrapping modulo NUM_REQ.
  - req_ready[winner] is driven high combinationally, only while in IDLE. All other bits are 0.
  - On an edge where any req_valid is high:
    - latch the winner's operands into eng_in1/eng_in2/eng_mode;
    - eng_in2 is forced to 0 when the mode is hash;
    - latch the winner into job_id, set rr_ptr = winner, clear the watchdog, set eng_go = 1, go to RUN.
  - Requesters hold req_valid and operands stable until they see req_ready; req_valid dropping before grant is legal.
- RUN:
  - eng_go = 1, and eng_in1/eng_in2/eng_mode stay constant.
  - The watchdog increments every cycle.
  - eng_valid = 1: resp_data <= eng_out, resp_id <= job_id, resp_timeout <= 0, resp_valid <= 1, eng_go <= 0, go to RESP.
  - Otherwise, watchdog == TIMEOUT_CYCLES-1: resp_data <= 0, resp_timeout <= 1, resp_valid <= 1, eng_go <= 0, go to RESP.
  - eng_valid takes priority over timeout in the same cycle.
- RESP:
  - eng_go = 0. This guarantees at least one go-low cycle between jobs, which resets the engine.
  - Response outputs are held stable while resp_valid is high.
  - resp_valid & resp_ready: resp_valid <= 0, go to IDLE. A new grant is possible in the cycle after that.
- Latency:
  - Accept on edge T; eng_go is high from T.
  - If the engine first asserts eng_valid in cycle T+L, resp_valid is high from T+L+1.
  - Minimum job-to-job spacing is L+3 cycles with resp_ready tied high.
- Fairness: every continuously-requesting requester is granted within NUM_REQ jobs.
- resp_ready high while resp_valid is low is ignored.
- The single-job structure means no buffering: resp_valid may only rise from RUN.

Test Plan:
- Single hash: NUM_REQ=4; the bench engine model has latency L=20 and result = in1 ^ in2. req_valid[2]=1, in1=0x12345678 (31-bit 0x12345678), in2=0x7FFFFFFF, mode=0. Required: eng_in2 = 0; resp_data = 0x12345678, resp_id = 2 and resp_timeout = 0 in cycle T+21; req_ready[2] pulsed for 1 cycle.
- Compress: req 1 with in1=0x0000000F, in2=0x000000F0, mode=1 -> eng_mode = 1, resp_data = 0x000000FF, resp_id = 1.
- Round robin: all four requesters hold req_valid from reset, with resp_ready=1 -> grant order is 0,1,2,3,0,1. Each job must be separated by at least one cycle of eng_go = 0.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_data/resp_id are stable, eng_go = 0, no req_ready pulses, busy = 1. On resp_ready=1, state returns to IDLE in the next cycle.
- Timeout: the engine model never asserts valid, with TIMEOUT_CYCLES=8 -> resp_valid rises on the edge ending the 8th RUN cycle, with resp_timeout = 1 and resp_data = 0. The next job completes normally.
- Reset mid-RUN: assert reset in cycle 5 of RUN -> the next cycle has eng_go = 0 and resp_valid = 0, with no response for the dropped job. After reset, requester 0 wins first.
